// File: rtl/had_bkpt_pkg.sv
// Shared types and constants for the breakpoint controller.
package had_bkpt_pkg;

  localparam int CNT_W = 8;

  // Encodings are visible on ctrl_fsm_st, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_REQ   = 2'b10,
    ST_DEBUG = 2'b11
  } bkpt_st_e;

  // Configuration bits latched from the register block on regs_bkpt_wr.
  typedef struct packed {
    logic en;
    logic chain_en;
    logic cnt_en;
  } bkpt_cfg_t;

  // True in the two states where hits are evaluated and a config write resets the FSM.
  function automatic logic is_watch_state(input bkpt_st_e st);
    return (st == ST_IDLE) || (st == ST_ARMED);
  endfunction

endpackage

// File: rtl/had_bkpt_cnt.sv
// Breakpoint-A hit counter: parallel load, decrement saturating at zero, zero flag.
module had_bkpt_cnt
  import had_bkpt_pkg::*;
(
  input  logic             had_clk,
  input  logic             hadrst_b,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load has priority over decrement; decrement stops at zero instead of wrapping.
  always_ff @(posedge had_clk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/had_bkpt_ctrl.sv
// Breakpoint controller: combines comparator hits A and B (optionally counted
// and chained) into a debug-entry request, and tracks the request/debug handshake.
module had_bkpt_ctrl
  import had_bkpt_pkg::*;
(
  input  logic             had_clk,
  input  logic             hadrst_b,
  input  logic             bkpta_hit,
  input  logic             bkptb_hit,
  input  logic             iu_yy_xx_dbgon,
  input  logic             regs_bkpt_wr,
  input  logic             regs_bkpt_en,
  input  logic             regs_chain_en,
  input  logic             regs_cnt_en,
  input  logic [CNT_W-1:0] regs_cnt_init,
  input  logic             regs_stat_clr,
  output logic             had_core_dbg_mode_req,
  output logic [1:0]       ctrl_bkpt_stat,
  output logic [CNT_W-1:0] ctrl_cnt_val,
  output logic             ctrl_bkptb_armed,
  output logic [1:0]       ctrl_fsm_st
);

  // The counter is the only consumer of cnt_init and loads it straight from the
  // write strobe, so no separate cnt_init copy is held in the config register.
  bkpt_cfg_t        cfg;
  bkpt_st_e         st;
  bkpt_st_e         st_nxt;
  logic [1:0]       stat;
  logic [1:0]       stat_set;
  logic [1:0]       stat_nxt;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             hit_ok;
  logic             wr_reset;
  logic             eff_a;
  logic [CNT_W-1:0] cnt;

  // Latch configuration on every write strobe, whatever the FSM state.
  always_ff @(posedge had_clk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      cfg <= '0;
    end else if (regs_bkpt_wr) begin
      cfg <= '{en: regs_bkpt_en, chain_en: regs_chain_en, cnt_en: regs_cnt_en};
    end
  end

  // Hits are only meaningful outside debug, when enabled, and while watching.
  assign hit_ok   = cfg.en && !iu_yy_xx_dbgon && is_watch_state(st);
  // A config write while watching restarts the FSM; in REQ/DEBUG it only updates cfg.
  assign wr_reset = regs_bkpt_wr && is_watch_state(st);
  // An A hit counts as a trigger once the counter is exhausted or counting is off.
  assign eff_a    = bkpta_hit && (!cfg.cnt_en || cnt_zero);

  // Next-state, status-set and counter-decrement decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    st_nxt   = st;
    stat_set = 2'b00;
    cnt_dec  = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (hit_ok) begin
          cnt_dec = bkpta_hit && cfg.cnt_en && !cnt_zero;
          if (cfg.chain_en) begin
            if (eff_a) st_nxt = ST_ARMED;
          end else if (eff_a || bkptb_hit) begin
            st_nxt   = ST_REQ;
            stat_set = {bkptb_hit, eff_a};
          end
        end
      end
      ST_ARMED: begin
        if (hit_ok && bkptb_hit) begin
          st_nxt   = ST_REQ;
          stat_set = 2'b11;
        end
      end
      ST_REQ: begin
        if (iu_yy_xx_dbgon) st_nxt = ST_DEBUG;
      end
      ST_DEBUG: begin
        if (!iu_yy_xx_dbgon) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase

    // Disabled while watching: fall back to IDLE.
    if (is_watch_state(st) && !cfg.en) begin
      st_nxt = ST_IDLE;
    end

    // A config write while watching overrides any hit in the same cycle.
    if (wr_reset) begin
      st_nxt   = ST_IDLE;
      stat_set = 2'b00;
      cnt_dec  = 1'b0;
    end

    // Sticky status: a set in the same cycle as a clear survives the clear.
    if (wr_reset) begin
      stat_nxt = 2'b00;
    end else if (regs_stat_clr) begin
      stat_nxt = stat_set;
    end else begin
      stat_nxt = stat | stat_set;
    end
  end

  // FSM state and its registered outputs.
  always_ff @(posedge had_clk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      // NOTE: every flop here is control state, so all take the async reset.
      st                    <= ST_IDLE;
      had_core_dbg_mode_req <= 1'b0;
      ctrl_bkptb_armed      <= 1'b0;
      stat                  <= 2'b00;
    end else begin
      st                    <= st_nxt;
      had_core_dbg_mode_req <= (st_nxt == ST_REQ);
      ctrl_bkptb_armed      <= (st_nxt == ST_ARMED);
      stat                  <= stat_nxt;
    end
  end

  had_bkpt_cnt u_cnt (
    .had_clk  (had_clk),
    .hadrst_b (hadrst_b),
    .load     (wr_reset),
    .load_val (regs_cnt_init),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign ctrl_bkpt_stat = stat;
  assign ctrl_cnt_val   = cnt;
  assign ctrl_fsm_st    = st;

endmodule

// File: tb/tb_had_bkpt_ctrl.sv
// Directed bench for had_bkpt_ctrl with hand-computed expected values.
module tb_had_bkpt_ctrl;

  logic       had_clk = 1'b0;
  logic       hadrst_b;
  logic       bkpta_hit;
  logic       bkptb_hit;
  logic       iu_yy_xx_dbgon;
  logic       regs_bkpt_wr;
  logic       regs_bkpt_en;
  logic       regs_chain_en;
  logic       regs_cnt_en;
  logic [7:0] regs_cnt_init;
  logic       regs_stat_clr;
  logic       had_core_dbg_mode_req;
  logic [1:0] ctrl_bkpt_stat;
  logic [7:0] ctrl_cnt_val;
  logic       ctrl_bkptb_armed;
  logic [1:0] ctrl_fsm_st;

  int n_vec = 0;
  int n_err = 0;
  int armed_cycles;

  localparam int IDLE  = 0;
  localparam int ARMED = 1;
  localparam int REQ   = 2;
  localparam int DEBUG = 3;

  had_bkpt_ctrl dut (
    .had_clk               (had_clk),
    .hadrst_b              (hadrst_b),
    .bkpta_hit             (bkpta_hit),
    .bkptb_hit             (bkptb_hit),
    .iu_yy_xx_dbgon        (iu_yy_xx_dbgon),
    .regs_bkpt_wr          (regs_bkpt_wr),
    .regs_bkpt_en          (regs_bkpt_en),
    .regs_chain_en         (regs_chain_en),
    .regs_cnt_en           (regs_cnt_en),
    .regs_cnt_init         (regs_cnt_init),
    .regs_stat_clr         (regs_stat_clr),
    .had_core_dbg_mode_req (had_core_dbg_mode_req),
    .ctrl_bkpt_stat        (ctrl_bkpt_stat),
    .ctrl_cnt_val          (ctrl_cnt_val),
    .ctrl_bkptb_armed      (ctrl_bkptb_armed),
    .ctrl_fsm_st           (ctrl_fsm_st)
  );

  always #5 had_clk = ~had_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge had_clk);
    #1;
  endtask

  task automatic cfg_write(input logic en, input logic chain, input logic cen,
                           input logic [7:0] init);
    regs_bkpt_en  = en;
    regs_chain_en = chain;
    regs_cnt_en   = cen;
    regs_cnt_init = init;
    regs_bkpt_wr  = 1'b1;
    step();
    regs_bkpt_wr  = 1'b0;
  endtask

  task automatic hit(input logic a, input logic b);
    bkpta_hit = a;
    bkptb_hit = b;
    step();
    bkpta_hit = 1'b0;
    bkptb_hit = 1'b0;
  endtask

  task automatic exit_dbg();
    iu_yy_xx_dbgon = 1'b1;
    step();
    iu_yy_xx_dbgon = 1'b0;
    step();
  endtask

  initial begin
    hadrst_b       = 1'b0;
    bkpta_hit      = 1'b0;
    bkptb_hit      = 1'b0;
    iu_yy_xx_dbgon = 1'b0;
    regs_bkpt_wr   = 1'b0;
    regs_bkpt_en   = 1'b0;
    regs_chain_en  = 1'b0;
    regs_cnt_en    = 1'b0;
    regs_cnt_init  = 8'd0;
    regs_stat_clr  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_st", int'(ctrl_fsm_st), IDLE);
    check("rst_req", int'(had_core_dbg_mode_req), 0);
    check("rst_stat", int'(ctrl_bkpt_stat), 0);
    check("rst_cnt", int'(ctrl_cnt_val), 0);
    check("rst_armed", int'(ctrl_bkptb_armed), 0);
    hadrst_b = 1'b1;
    step();

    // Config is disabled after reset: hits are ignored
    hit(1'b1, 1'b1);
    check("dis_st", int'(ctrl_fsm_st), IDLE);
    check("dis_stat", int'(ctrl_bkpt_stat), 0);

    // Counted trigger: init 3, four A pulses
    cfg_write(1'b1, 1'b0, 1'b1, 8'd3);
    check("cnt_load", int'(ctrl_cnt_val), 3);
    hit(1'b1, 1'b0);
    check("cnt_a1", int'(ctrl_cnt_val), 2);
    step();
    hit(1'b1, 1'b0);
    check("cnt_a2", int'(ctrl_cnt_val), 1);
    step();
    hit(1'b1, 1'b0);
    check("cnt_a3", int'(ctrl_cnt_val), 0);
    check("cnt_a3_req", int'(had_core_dbg_mode_req), 0);
    step();
    hit(1'b1, 1'b0);
    check("cnt_a4_sat", int'(ctrl_cnt_val), 0);
    check("cnt_a4_req", int'(had_core_dbg_mode_req), 1);
    check("cnt_a4_st", int'(ctrl_fsm_st), REQ);
    check("cnt_a4_stat", int'(ctrl_bkpt_stat), 1);

    // Handshake: req held while dbgon low; hits and config writes in REQ
    for (int i = 0; i < 9; i++) step();
    check("hs_req_held", int'(had_core_dbg_mode_req), 1);
    hit(1'b0, 1'b1);
    check("hs_hit_in_req", int'(ctrl_bkpt_stat), 1);
    cfg_write(1'b1, 1'b0, 1'b1, 8'd5);
    check("wr_req_req", int'(had_core_dbg_mode_req), 1);
    check("wr_req_cnt", int'(ctrl_cnt_val), 0);
    check("wr_req_stat", int'(ctrl_bkpt_stat), 1);
    iu_yy_xx_dbgon = 1'b1;
    step();
    check("hs_debug_st", int'(ctrl_fsm_st), DEBUG);
    check("hs_debug_req", int'(had_core_dbg_mode_req), 0);
    hit(1'b1, 1'b1);
    check("hs_hit_dbg_st", int'(ctrl_fsm_st), DEBUG);
    check("hs_hit_dbg_stat", int'(ctrl_bkpt_stat), 1);
    iu_yy_xx_dbgon = 1'b0;
    step();
    check("hs_idle_st", int'(ctrl_fsm_st), IDLE);
    check("hs_stat_sticky", int'(ctrl_bkpt_stat), 1);
    // dbgon high while IDLE also masks hits
    iu_yy_xx_dbgon = 1'b1;
    hit(1'b0, 1'b1);
    iu_yy_xx_dbgon = 1'b0;
    check("dbgon_idle_st", int'(ctrl_fsm_st), IDLE);
    regs_stat_clr = 1'b1;
    step();
    regs_stat_clr = 1'b0;
    check("stat_clr", int'(ctrl_bkpt_stat), 0);

    // Simultaneous hits, chain off
    cfg_write(1'b1, 1'b0, 1'b0, 8'd0);
    hit(1'b1, 1'b1);
    check("sim_nochain_st", int'(ctrl_fsm_st), REQ);
    check("sim_nochain_req", int'(had_core_dbg_mode_req), 1);
    check("sim_nochain_stat", int'(ctrl_bkpt_stat), 3);
    exit_dbg();

    // Simultaneous hits, chain on: B ignored in IDLE
    cfg_write(1'b1, 1'b1, 1'b0, 8'd0);
    check("wr_idle_stat", int'(ctrl_bkpt_stat), 0);
    hit(1'b1, 1'b1);
    check("sim_chain_st", int'(ctrl_fsm_st), ARMED);
    check("sim_chain_armed", int'(ctrl_bkptb_armed), 1);
    check("sim_chain_req", int'(had_core_dbg_mode_req), 0);

    // Config write in ARMED
    cfg_write(1'b1, 1'b1, 1'b1, 8'd2);
    check("wr_armed_st", int'(ctrl_fsm_st), IDLE);
    check("wr_armed_cnt", int'(ctrl_cnt_val), 2);
    check("wr_armed_stat", int'(ctrl_bkpt_stat), 0);
    check("wr_armed_armed", int'(ctrl_bkptb_armed), 0);

    // Chaining: A, then B five cycles later; an extra A in ARMED is inert
    cfg_write(1'b1, 1'b1, 1'b0, 8'd0);
    hit(1'b1, 1'b0);
    armed_cycles = int'(ctrl_bkptb_armed);
    for (int i = 0; i < 4; i++) begin
      bkpta_hit = (i == 1);
      step();
      bkpta_hit = 1'b0;
      armed_cycles += int'(ctrl_bkptb_armed);
    end
    hit(1'b0, 1'b1);
    check("chain_armed_cycles", armed_cycles, 5);
    check("chain_armed_low", int'(ctrl_bkptb_armed), 0);
    check("chain_req", int'(had_core_dbg_mode_req), 1);
    check("chain_stat", int'(ctrl_bkpt_stat), 3);

    // Write en=0 while in REQ: REQ/DEBUG completes, then hits are ignored
    cfg_write(1'b0, 1'b0, 1'b0, 8'd0);
    check("dis_req_req", int'(had_core_dbg_mode_req), 1);
    exit_dbg();
    check("dis_back_idle", int'(ctrl_fsm_st), IDLE);
    hit(1'b1, 1'b1);
    check("dis_hit_st", int'(ctrl_fsm_st), IDLE);

    // Hit coinciding with stat clear: the set wins
    cfg_write(1'b1, 1'b0, 1'b0, 8'd0);
    regs_stat_clr = 1'b1;
    hit(1'b0, 1'b1);
    regs_stat_clr = 1'b0;
    check("clr_hit_stat", int'(ctrl_bkpt_stat), 2);
    check("clr_hit_st", int'(ctrl_fsm_st), REQ);
    exit_dbg();

    // Config write coinciding with a hit: the write wins
    bkptb_hit = 1'b1;
    cfg_write(1'b1, 1'b0, 1'b0, 8'd7);
    bkptb_hit = 1'b0;
    check("wr_hit_st", int'(ctrl_fsm_st), IDLE);
    check("wr_hit_stat", int'(ctrl_bkpt_stat), 0);
    check("wr_hit_cnt", int'(ctrl_cnt_val), 7);

    // Reset during REQ
    hit(1'b0, 1'b1);
    check("rreq_pre", int'(had_core_dbg_mode_req), 1);
    hadrst_b = 1'b0;
    #1;
    check("rreq_req_now", int'(had_core_dbg_mode_req), 0);
    check("rreq_st_now", int'(ctrl_fsm_st), IDLE);
    step();
    hadrst_b = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rreq_after_req", int'(had_core_dbg_mode_req), 0);
    hit(1'b0, 1'b1);
    check("rreq_after_st", int'(ctrl_fsm_st), IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
